// File: rtl/pad_row_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pad_row_fifo_pkg                                             |
// | Description : Shared constants, element type and index helpers for the    |
// |               padded-row staging FIFO.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pad_row_fifo_pkg;

    localparam int c_data_width = 8;
    localparam int c_lanes      = 4;
    localparam int c_pad_l      = 1;
    localparam int c_pad_r      = 2;
    localparam int ROW_MAX      = c_pad_l + c_lanes + c_pad_r;

    typedef logic [c_data_width-1:0] elem_t;

    function automatic int row_len(input logic pad_en,
                                   input int   lanes = c_lanes,
                                   input int   pad_l = c_pad_l,
                                   input int   pad_r = c_pad_r);
        return pad_en ? (pad_l + lanes + pad_r) : lanes;
    endfunction

    // offset never exceeds depth, so one conditional subtract replaces a modulo
    function automatic int wrap_idx(input int base, input int offset, input int depth);
        int sum;
        sum = base + offset;
        return (sum >= depth) ? (sum - depth) : sum;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pad_row_fifo_expand.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pad_row_expand                                               |
// | Description : Combinational expansion of one packed write word into the    |
// |               slot sequence (pads, MS lane first data, pads) and length.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pad_row_expand
    import pad_row_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int PAD_L      = 1,
    parameter int PAD_R      = 2
) (
    input  logic [DATA_WIDTH*LANES-1:0]              wr_data,
    input  logic                                     pad_en,
    input  logic [DATA_WIDTH-1:0]                    pad_val,
    output logic [DATA_WIDTH-1:0]                    row [PAD_L+LANES+PAD_R],
    output logic [$clog2(PAD_L+LANES+PAD_R+1)-1:0]   len
);

    localparam int c_slots = PAD_L + LANES + PAD_R;
    localparam int c_len_w = $clog2(c_slots + 1);

    assign len = c_len_w'(row_len(pad_en, LANES, PAD_L, PAD_R));

    for (genvar i = 0; i < c_slots; i++) begin : g_slot
        logic [DATA_WIDTH-1:0] w_padded;
        logic [DATA_WIDTH-1:0] w_raw;

        if (i >= PAD_L && i < PAD_L + LANES) begin : g_pad_data
            assign w_padded = wr_data[DATA_WIDTH*(LANES-(i-PAD_L))-1 -: DATA_WIDTH];
        end else begin : g_pad_fill
            assign w_padded = pad_val;
        end

        // slots beyond LANES are never written when padding is bypassed
        if (i < LANES) begin : g_raw_data
            assign w_raw = wr_data[DATA_WIDTH*(LANES-i)-1 -: DATA_WIDTH];
        end else begin : g_raw_fill
            assign w_raw = pad_val;
        end

        assign row[i] = pad_en ? w_padded : w_raw;
    end

endmodule
`default_nettype wire

// File: rtl/pad_row_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pad_row_fifo                                                 |
// | Description : Input staging FIFO writing one padded row per accepted word  |
// |               and streaming it out one element per read.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pad_row_fifo
    import pad_row_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int PAD_L      = 1,
    parameter int PAD_R      = 2,
    parameter int DEPTH      = 14
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            pad_en,
    input  logic [DATA_WIDTH-1:0]           pad_val,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [DATA_WIDTH*LANES-1:0]     wr_data,
    output logic                            wr_err,
    input  logic                            rd_en,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]      count,
    output logic                            full,
    output logic                            empty
);

    localparam int c_slots = PAD_L + LANES + PAD_R;
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_len_w = $clog2(c_slots + 1);

    if (DEPTH < c_slots) begin : g_depth_check
        $error("pad_row_fifo: DEPTH must hold at least one full padded row");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]    r_wr_ptr;
    logic [c_ptr_w-1:0]    r_rd_ptr;
    logic [c_cnt_w-1:0]    r_count;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  r_wr_err;

    logic [DATA_WIDTH-1:0] w_row [c_slots];
    logic [c_len_w-1:0]    w_row_len;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    pad_row_expand #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .PAD_L      (PAD_L),
        .PAD_R      (PAD_R)
    ) u_expand (
        .wr_data (wr_data),
        .pad_en  (pad_en),
        .pad_val (pad_val),
        .row     (w_row),
        .len     (w_row_len)
    );

    // credit is judged on the current count only; a same-cycle read does not help
    assign wr_ready = (c_cnt_w'(DEPTH) - r_count) >= c_cnt_w'(w_row_len);
    assign w_wr_acc = wr_valid && wr_ready && !flush;
    assign w_rd_acc = rd_en && !empty && !flush;

    assign count    = r_count;
    assign full     = (r_count == c_cnt_w'(DEPTH));
    assign empty    = (r_count == '0);
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign wr_err   = r_wr_err;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int i = 0; i < c_slots; i++) begin
                if (i < int'(w_row_len)) begin
                    r_mem[c_ptr_w'(wrap_idx(int'(r_wr_ptr), i, DEPTH))] <= w_row[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
        end else begin
            r_wr_err   <= wr_valid && !wr_ready;
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= r_mem[r_rd_ptr];
                r_rd_ptr  <= c_ptr_w'(wrap_idx(int'(r_rd_ptr), 1, DEPTH));
            end
            if (w_wr_acc) begin
                r_wr_ptr <= c_ptr_w'(wrap_idx(int'(r_wr_ptr), int'(w_row_len), DEPTH));
            end
            r_count <= r_count
                     + (w_wr_acc ? c_cnt_w'(w_row_len) : '0)
                     - (w_rd_acc ? c_cnt_w'(1) : '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pad_row_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pad_row_fifo                                              |
// | Description : Directed self-checking bench for pad_row_fifo (DEPTH=14).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pad_row_fifo;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        pad_en;
    logic [7:0]  pad_val;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        wr_err;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [3:0]  count;
    logic        full;
    logic        empty;

    int n_cmp;
    int n_err;
    logic [7:0] exp_q [$];

    pad_row_fifo #(
        .DATA_WIDTH (8),
        .LANES      (4),
        .PAD_L      (1),
        .PAD_R      (2),
        .DEPTH      (14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .pad_en   (pad_en),
        .pad_val  (pad_val),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_err   (wr_err),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_row(input logic [31:0] d, input logic pe, input logic [7:0] pv);
        wr_data  = d;
        pad_en   = pe;
        pad_val  = pv;
        wr_valid = 1'b1;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk({tag, "_valid"}, 32'(rd_valid), 32'h1);
        chk({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    task automatic drain(input string tag);
        foreach (exp_q[i]) rd_chk($sformatf("%s_%0d", tag, i), exp_q[i]);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        flush    = 1'b0;
        pad_en   = 1'b0;
        pad_val  = 8'h00;
        wr_valid = 1'b0;
        wr_data  = 32'h0;
        rd_en    = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_rd_valid", 32'(rd_valid), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);
        cyc();
        rst = 1'b0;
        cyc();

        // 1: single padded row
        wr_row(32'hAABBCCDD, 1'b1, 8'h00);
        chk("t1_count", 32'(count), 32'd7);
        exp_q = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 8'h00};
        drain("t1");
        cyc();
        chk("t1_valid_drop", 32'(rd_valid), 32'h0);
        chk("t1_empty", 32'(empty), 32'h1);
        chk("t1_count_end", 32'(count), 32'd0);

        // 2: fill to full, partial drain, credit return
        wr_row(32'hA1A2A3A4, 1'b1, 8'h55);
        wr_row(32'hB1B2B3B4, 1'b1, 8'h66);
        pad_en = 1'b1;
        #1;
        chk("t2_full", 32'(full), 32'h1);
        chk("t2_ready_full", 32'(wr_ready), 32'h0);
        exp_q = '{8'h55, 8'hA1, 8'hA2};
        drain("t2a");
        chk("t2_count11", 32'(count), 32'd11);
        chk("t2_ready11", 32'(wr_ready), 32'h0);
        exp_q = '{8'hA3, 8'hA4, 8'h55, 8'h55};
        drain("t2b");
        chk("t2_count7", 32'(count), 32'd7);
        chk("t2_ready7", 32'(wr_ready), 32'h1);

        // 3: simultaneous write and read at count 7
        wr_data  = 32'h11223344;
        pad_en   = 1'b1;
        pad_val  = 8'hFF;
        wr_valid = 1'b1;
        rd_en    = 1'b1;
        cyc();
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        chk("t3_rd_valid", 32'(rd_valid), 32'h1);
        chk("t3_rd_data", 32'(rd_data), 32'h66);
        chk("t3_count", 32'(count), 32'd13);
        exp_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'h66, 8'h66,
                  8'hFF, 8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF};
        drain("t3");
        chk("t3_empty", 32'(empty), 32'h1);

        // 4: pad bypass, interleaved rows, raw row wrapping mid-row
        wr_row(32'h01020304, 1'b0, 8'hEE);
        chk("t4_count4", 32'(count), 32'd4);
        wr_row(32'h0A0B0C0D, 1'b1, 8'h77);
        chk("t4_count11", 32'(count), 32'd11);
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        drain("t4a");
        wr_row(32'h05060708, 1'b0, 8'hEE);
        chk("t4_count11b", 32'(count), 32'd11);
        exp_q = '{8'h77, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h77, 8'h77,
                  8'h05, 8'h06, 8'h07, 8'h08};
        drain("t4b");

        // 5: overflow on a full FIFO whose second row wraps in its trailing pad
        wr_row(32'hC1C2C3C4, 1'b1, 8'h99);
        wr_row(32'hD1D2D3D4, 1'b1, 8'h88);
        chk("t5_full", 32'(full), 32'h1);
        wr_data  = 32'hEEEEEEEE;
        pad_en   = 1'b0;
        wr_valid = 1'b1;
        #1;
        chk("t5_ready", 32'(wr_ready), 32'h0);
        cyc();
        wr_valid = 1'b0;
        chk("t5_wr_err", 32'(wr_err), 32'h1);
        chk("t5_count", 32'(count), 32'd14);
        cyc();
        chk("t5_wr_err_drop", 32'(wr_err), 32'h0);
        exp_q = '{8'h99, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h99, 8'h99,
                  8'h88, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'h88, 8'h88};
        drain("t5");
        rd_en = 1'b1;
        cyc();
        rd_en = 1'b0;
        chk("t5_empty_rd_valid", 32'(rd_valid), 32'h0);
        chk("t5_empty_rd_hold", 32'(rd_data), 32'h88);
        chk("t5_empty_count", 32'(count), 32'd0);

        // 6a: asynchronous reset between edges in mid-drain
        wr_row(32'h01020304, 1'b1, 8'h42);
        exp_q = '{8'h42, 8'h01};
        drain("t6a");
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_count", 32'(count), 32'd0);
        chk("t6_async_valid", 32'(rd_valid), 32'h0);
        chk("t6_async_data", 32'(rd_data), 32'h0);
        #2;
        rst = 1'b0;
        cyc();

        // 6b: flush beats a same-cycle write and read
        wr_row(32'h0A0B0C0D, 1'b1, 8'h5A);
        rd_chk("t6b_first", 8'h5A);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 32'h12345678;
        pad_en   = 1'b1;
        pad_val  = 8'hAB;
        rd_en    = 1'b1;
        cyc();
        flush    = 1'b0;
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        chk("t6_flush_count", 32'(count), 32'd0);
        chk("t6_flush_empty", 32'(empty), 32'h1);
        chk("t6_flush_valid", 32'(rd_valid), 32'h0);
        chk("t6_flush_wr_err", 32'(wr_err), 32'h0);
        chk("t6_flush_hold", 32'(rd_data), 32'h5A);
        wr_row(32'h01020304, 1'b1, 8'h33);
        exp_q = '{8'h33, 8'h01, 8'h02};
        drain("t6c");
        chk("t6_post_count", 32'(count), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
